button_conditioner: RTL
=======================

# button_conditioner

Conditions the raw, active-low board pushbuttons into clean, active-high control signals for the counting FSM and other front-panel logic. Each button is synchronised into the `clk30` domain, debounced with a per-button stability counter, and presented as a debounced level plus single-cycle press/release pulses. An optional per-button long-press detector is also available. The block sits directly between the `button` pins and the consumers of `go`/`rst`-style controls.

## Interface
- `NUM_BUTTONS`, default 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 300000 (10 ms at 30 MHz): consecutive stable samples required to accept a change; legal range is 2 or more.
- `LONG_CYCLES`, default 30000000 (1 s at 30 MHz): pressed cycles before `long_press` fires; legal range is 1 or more.

- `clk30`  input  1  system clock, 30 MHz.
- `rst`  input  1  reset, asynchronous, active-high.
- `button_n`  input  NUM_BUTTONS  raw pins, active-low (0 = pressed), asynchronous to `clk30`.
- `level`  output  NUM_BUTTONS  debounced state, 1 = pressed.
- `pressed`  output  NUM_BUTTONS  one-cycle pulse on an accepted press.
- `released`  output  NUM_BUTTONS  one-cycle pulse on an accepted release.
- `long_press`  output  NUM_BUTTONS  one-cycle pulse when a press has lasted LONG_CYCLES (see Configuration).

## Operation
- Each channel is independent, and all channels run the same logic.
- **Synchroniser:** two flops per bit, `sync1` then `sync2`. Both reset to 1 (released), and the input is inverted after `sync2`.
- **Debounce states:** STABLE_RELEASED (`level` = 0) and STABLE_PRESSED (`level` = 1). The counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide.
- Each edge, compare the synchronised pressed value `s` against `level`:
  - If `s` equals `level`: `cnt` is set to 0.
  - If `s` differs and `cnt` is below DEBOUNCE_CYCLES-1: `cnt` increments.
  - If `s` differs and `cnt` equals DEBOUNCE_CYCLES-1: toggle `level`, set `cnt` to 0, and pulse `pressed` or `released` according to the new `level`.
- **Glitch rejection:** a disturbance shorter than DEBOUNCE_CYCLES samples returns `cnt` to 0 and produces no output change.
- **Pulse rules:** `pressed` and `released` are registered and last exactly one `clk30` cycle. They are never asserted together on one channel. Each is asserted in the same cycle that `level` first shows its new value.
- **Counter arithmetic:** `cnt` never wraps, because it is cleared at its terminal value.
- **Long-press counter:** `lcnt` is `$clog2(LONG_CYCLES+1)` bits wide.
  - While `level` = 1, `lcnt` counts up and saturates at LONG_CYCLES.
  - `long_press` pulses for one cycle on the edge where `lcnt` reaches LONG_CYCLES. It fires at most once per press.
  - `level` = 0 clears `lcnt`.
- **Slow-domain consumers:** consumers on slow or divided clocks must use `level`, because the pulses are `clk30`-wide only.

## Timing
- **Reset values:** `level`, `pressed`, `released` and `long_press` are 0; `cnt` and `lcnt` are 0; `sync1` and `sync2` are 1. Reset takes effect immediately on assertion, including mid-count or mid-press.
- **Release of reset:** if a button is held through the release of `rst`, it is accepted as a press after normal debounce latency. It is never treated as pressed at reset.
- **Debounce latency:** take edge 0 as the first edge that samples a new, stable raw value.
  - `sync2` updates at edge 1.
  - `level`, `pressed` and `released` update at edge DEBOUNCE_CYCLES+1.
- **Long-press latency:** `long_press` is asserted LONG_CYCLES edges after the edge that set `level` to 1.
- **Release before long press:** if the button is released before `lcnt` saturates, there is no `long_press`.
- **Release at the boundary:** if the debounced release toggles `level` on the same edge that `lcnt` would reach LONG_CYCLES, the release wins. `released` pulses and `long_press` does not.

## Configuration
- Macro `BUTTON_LONG_PRESS_EN`.
- **Defined:** the `lcnt` counters and `long_press` logic are built as described above.
- **Undefined:** no `lcnt` registers are instantiated, and `long_press` is tied to all zeros. Every other output is cycle-identical.

## Test plan
Bench parameters for all scenarios: DEBOUNCE_CYCLES = 4, LONG_CYCLES = 10, NUM_BUTTONS = 2.

1. **Reset:** assert `rst` with `button_n` = 2'b00 (both pressed).
   - All outputs must be 0 while reset is held.
   - After release of reset, `level` = 2'b11 and `pressed` = 2'b11 must appear for one cycle, exactly 5 edges after release.
2. **Clean press:** drive `button_n[0]` from 1 to 0 before edge 0.
   - `level[0]` = 1 and `pressed[0]` = 1 must appear after edge 5.
   - `pressed[0]` must return to 0 at edge 6; channel 1 stays unchanged.
3. **Glitch rejection:** apply a 3-cycle low pulse on `button_n[1]`, then a 4-cycle low pulse.
   - The 3-cycle pulse produces no `level` or `pulse` change.
   - The 4-cycle pulse produces `pressed[1]`.
4. **Bouncy release:** hold button 0 pressed, then release it with 1/0/1/0 chatter followed by a stable high.
   - `released[0]` must pulse exactly once, DEBOUNCE_CYCLES+1 edges after the last transition.
5. **Long press (macro defined):** hold button 0 pressed.
   - `long_press[0]` must pulse exactly once, 10 edges after `level[0]` rises.
   - It must not pulse again while the button is held.
   - Repeat with the release landing on the saturation edge: `released[0]` pulses and `long_press[0]` stays 0.
   - Run the same bench with the macro undefined: `long_press` stays 0 throughout.
6. **Reset mid-operation:** assert `rst` while `cnt[0]` = 2 and button 1 is held with `lcnt[1]` = 6.
   - All outputs must go to 0 asynchronously.
   - No stale pulse may appear after release of reset.

Source files
------------

// File: rtl/button_conditioner.sv
// Active-low pushbutton conditioner: 2-flop synchroniser, stability-count debounce,
// press/release pulses and an optional long-press pulse (enabled by BUTTON_LONG_PRESS_EN).

module button_channel #(
    parameter int DEBOUNCE_CYCLES = 300000,
    parameter int LONG_CYCLES     = 30000000
) (
    input  logic clk30,
    input  logic rst,
    input  logic btn_n_i,
    output logic level_o,
    output logic pressed_o,
    output logic released_o,
    output logic long_press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE_RELEASED = 1'b0,
        STABLE_PRESSED  = 1'b1
    } db_state_e;

    db_state_e     state_q;
    logic          sync1_q, sync2_q;
    logic          s;
    logic [CW-1:0] cnt_q;
    logic          pressed_q, released_q;

    // Synchroniser resets to "released" so a held button is never pressed at reset.
    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign s       = ~sync2_q;
    assign level_o = (state_q == STABLE_PRESSED);

    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            state_q    <= STABLE_RELEASED;
            cnt_q      <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            if (s == level_o) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_TERM) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
                case (state_q)
                    STABLE_RELEASED: begin
                        state_q   <= STABLE_PRESSED;
                        pressed_q <= 1'b1;
                    end
                    default: begin
                        state_q    <= STABLE_RELEASED;
                        released_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign pressed_o  = pressed_q;
    assign released_o = released_q;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LSAT    = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LSAT_M1 = LW'(LONG_CYCLES - 1);

    logic          release_edge;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          long_q, long_d;

    // A debounced release landing on the saturation edge suppresses long_press.
    assign release_edge = level_o & ~s & (cnt_q == CNT_TERM);

    always_comb begin
        lcnt_d = lcnt_q;
        long_d = 1'b0;
        if (!level_o || release_edge) begin
            lcnt_d = '0;
        end else if (lcnt_q != LSAT) begin
            lcnt_d = lcnt_q + 1'b1;
            long_d = (lcnt_q == LSAT_M1);
        end
    end

    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            long_q <= long_d;
        end
    end

    assign long_press_o = long_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule

module button_conditioner #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 300000,
    parameter int LONG_CYCLES     = 30000000
) (
    input  logic                   clk30,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] button_n,
    output logic [NUM_BUTTONS-1:0] level,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] released,
    output logic [NUM_BUTTONS-1:0] long_press
);
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk30        (clk30),
            .rst          (rst),
            .btn_n_i      (button_n[i]),
            .level_o      (level[i]),
            .pressed_o    (pressed[i]),
            .released_o   (released[i]),
            .long_press_o (long_press[i])
        );
    end

endmodule
